// File: rtl/jelly_param_update_control_pkg.sv
// jelly_param_update_control_pkg: state encodings shared by the parameter update controller
package jelly_param_update_control_pkg;
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE    = 1'b0;
    localparam state_t ST_PENDING = 1'b1;
endpackage

// File: rtl/jelly_param_update_control_if.sv
// jelly_param_update_control_if: control/status bundle between a host and the parameter update controller
interface jelly_param_update_control_if #(
    parameter int NUM         = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 2,
    parameter int INDEX_WIDTH = 1
) (
    input logic clk
);
    logic                      cke;
    logic                      s_we;
    logic [ADDR_WIDTH-1:0]     s_addr;
    logic [DATA_WIDTH-1:0]     s_wdata;
    logic                      s_update_req;
    logic                      s_auto;
    logic                      s_lock;
    logic                      s_cancel;
    logic                      in_trigger;
    logic [NUM*DATA_WIDTH-1:0] out_params;
    logic                      out_update;
    logic [INDEX_WIDTH-1:0]    out_index;
    logic                      out_pending;
    modport master (
        input  clk, out_params, out_update, out_index, out_pending,
        output cke, s_we, s_addr, s_wdata, s_update_req, s_auto, s_lock, s_cancel, in_trigger
    );
    modport slave (
        input  clk, cke, s_we, s_addr, s_wdata, s_update_req, s_auto, s_lock, s_cancel, in_trigger,
        output out_params, out_update, out_index, out_pending
    );
endinterface

// File: rtl/jelly_param_update_control.sv
// jelly_param_update_control: double-buffered parameter bank; shadow words are copied to the
// active bank at the first unlocked trigger after an update request
module jelly_param_update_control
    import jelly_param_update_control_pkg::*;
#(
    parameter int NUM         = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 2,
    parameter int INDEX_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cke,
    input  logic                      s_we,
    input  logic [ADDR_WIDTH-1:0]     s_addr,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic                      s_update_req,
    input  logic                      s_auto,
    input  logic                      s_lock,
    input  logic                      s_cancel,
    input  logic                      in_trigger,
    output logic [NUM*DATA_WIDTH-1:0] out_params,
    output logic                      out_update,
    output logic [INDEX_WIDTH-1:0]    out_index,
    output logic                      out_pending
);
    state_t                 state, state_next;
    logic                   we_ok, apply, req;
    logic                   update_next;
    logic [INDEX_WIDTH-1:0] index_next;
    logic [DATA_WIDTH-1:0]  shadow [NUM];
    logic [DATA_WIDTH-1:0]  active [NUM];

    assign we_ok = cke && s_we && (int'(s_addr) < NUM);
    assign apply = cke && (state == ST_PENDING) && in_trigger && !s_lock;
    assign req   = s_update_req || (we_ok && s_auto);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // a request arriving with an apply re-arms; cancel loses to a coinciding apply
    always_comb begin
        state_next = state;
        if (cke)
            state_next = (state == ST_IDLE) ? (req ? ST_PENDING : ST_IDLE)
                       : apply ? (req ? ST_PENDING : ST_IDLE)
                       : (s_cancel ? ST_IDLE : ST_PENDING);
    end

    always_comb begin
        update_next = cke ? apply : out_update;
        index_next  = apply ? out_index + INDEX_WIDTH'(1) : out_index;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_update <= 1'b0;
            out_index  <= '0;
        end else begin
            out_update <= update_next;
            out_index  <= index_next;
        end
    end

    assign out_pending = (state == ST_PENDING);

    // active copies the pre-write shadow when a write and an apply coincide
    for (genvar i = 0; i < NUM; i++) begin : g_bank
        always_ff @(posedge clk) begin
            if (reset) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end else begin
                if (we_ok && s_addr == ADDR_WIDTH'(i)) shadow[i] <= s_wdata;
                if (apply) active[i] <= shadow[i];
            end
        end
        assign out_params[i*DATA_WIDTH +: DATA_WIDTH] = active[i];
    end
endmodule
